multiplier_n: RTL and testbench

Parametrised successor to the 8-bit lab multiplier: an iterative shift-add multiplier of WIDTH bits producing a 2*WIDTH-bit product in registers A:B, with sign/overflow bit X.
- Adds selectable signed/unsigned mode, a latched multiplicand, explicit BUSY/DONE status and a one-result-per-press RUN handshake.
- Sits between the switch/button inputs and the hex display drivers on the board top level.

---
 rtl/mult_pkg.sv | 16 +
 rtl/nbit_add_sub.sv | 13 +
 rtl/multiplier_n.sv | 166 ++++++++++++++++
 tb/tb_multiplier_n.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } mult_state_t;

  // The bit counter only ever reaches WIDTH-1, so $clog2(WIDTH) bits are enough.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/nbit_add_sub.sv
// Combinational N-bit adder/subtractor: y = sub ? a - b : a + b (modulo 2^N).
module nbit_add_sub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] y_o
);

  assign y_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/multiplier_n.sv
// Iterative shift-add WIDTH x WIDTH multiplier producing {A,B}, signed or unsigned.
// Optional overflow flag output OVF when MULT_OVF_EN is defined.
module multiplier_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RUN,
  input  logic             CLEARA_LOADB,
  input  logic             SIGNED_MODE,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] AVAL,
  output logic [WIDTH-1:0] BVAL,
  output logic             X,
  output logic             BUSY,
  output logic             DONE
`ifdef MULT_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = cnt_width(WIDTH);

  mult_state_t      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic             x_q, x_d, sgn_q, sgn_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             last_s, start_s;
  logic [WIDTH:0]   sum_s;

  assign last_s  = (count_q == CW'(WIDTH - 1));
  assign start_s = (state_q == IDLE) && CLEARA_LOADB && !RUN;

  // The final partial product carries negative weight in signed mode, hence the subtract.
  nbit_add_sub #(.N(WIDTH + 1)) u_add_sub (
    .a_i   ({sgn_q & a_q[WIDTH-1], a_q}),
    .b_i   ({sgn_q & m_q[WIDTH-1], m_q}),
    .sub_i (sgn_q & last_s),
    .y_o   (sum_s)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    x_d     = x_q;
    sgn_d   = sgn_q;
    count_d = count_q;
    busy_d  = (state_q == ADD) || (state_q == SHIFT);
    done_d  = (state_q == HOLD);
    case (state_q)
      IDLE: begin
        if (!CLEARA_LOADB) begin
          a_d = '0;
          x_d = 1'b0;
          b_d = S;
        end else if (!RUN) begin
          m_d     = S;
          sgn_d   = SIGNED_MODE;
          a_d     = '0;
          x_d     = 1'b0;
          count_d = '0;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        if (b_q[0]) begin
          {x_d, a_d} = sum_s;
        end else begin
          {x_d, a_d} = {x_q, a_q};
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        {x_d, a_d, b_d} = {sgn_q & x_q, x_q, a_q, b_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (last_s) begin
          state_d = HOLD;
        end else begin
          state_d = ADD;
        end
      end
      HOLD: begin
        if (RUN) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      x_q     <= 1'b0;
      sgn_q   <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      x_q     <= x_d;
      sgn_q   <= sgn_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign AVAL = a_q;
  assign BVAL = b_q;
  assign X    = x_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

`ifdef MULT_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow is judged on the final shifted values, as they enter HOLD.
  always_comb begin
    ovf_d = ovf_q;
    if (start_s) begin
      ovf_d = 1'b0;
    end else if ((state_q == SHIFT) && last_s) begin
      if (sgn_q) begin
        ovf_d = ({x_d, a_d} != {(WIDTH + 1){b_d[WIDTH-1]}});
      end else begin
        ovf_d = (a_d != '0);
      end
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_multiplier_n.sv
// Directed self-checking bench for multiplier_n (WIDTH=8 and WIDTH=16 instances).
module tb_multiplier_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        run, cl, sm;
  logic [7:0]  s;
  logic [7:0]  a8, b8;
  logic        x8, busy8, done8, ovf8;
  logic        run16, cl16, sm16;
  logic [15:0] s16, a16, b16;
  logic        x16, busy16, done16, ovf16;

  int errors = 0;
  int checks = 0;

  multiplier_n #(.WIDTH(8)) dut8 (
    .CLK(clk), .RESET(rst_n), .RUN(run), .CLEARA_LOADB(cl), .SIGNED_MODE(sm), .S(s),
    .AVAL(a8), .BVAL(b8), .X(x8), .BUSY(busy8), .DONE(done8)
`ifdef MULT_OVF_EN
    , .OVF(ovf8)
`endif
  );

  multiplier_n #(.WIDTH(16)) dut16 (
    .CLK(clk), .RESET(rst_n), .RUN(run16), .CLEARA_LOADB(cl16), .SIGNED_MODE(sm16), .S(s16),
    .AVAL(a16), .BVAL(b16), .X(x16), .BUSY(busy16), .DONE(done16)
`ifdef MULT_OVF_EN
    , .OVF(ovf16)
`endif
  );

  task automatic load_b(input logic [7:0] v);
    @(negedge clk); cl = 1'b0; s = v;
    @(negedge clk); cl = 1'b1;
  endtask

  // Press RUN with multiplicand m; scramble S/SIGNED_MODE while busy; release after DONE.
  task automatic do_run(input logic [7:0] m, input logic sgnm, output int edges, output int busyc);
    int lat;
    lat = 0; busyc = 0;
    @(negedge clk); run = 1'b0; s = m; sm = sgnm;
    while (done8 !== 1'b1 && lat < 100) begin
      @(negedge clk); lat++;
      if (lat == 1) begin s = ~m; sm = ~sgnm; end
      if (busy8 === 1'b1) busyc++;
    end
    edges = lat - 1;
    run = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk8(input string name, input logic [7:0] ea, input logic [7:0] eb, input logic ex);
    checks++;
    if ({a8, b8, x8} !== {ea, eb, ex}) begin
      errors++;
      $display("FAIL %s: got A=%h B=%h X=%b want A=%h B=%h X=%b", name, a8, b8, x8, ea, eb, ex);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b1; cl = 1'b1; sm = 1'b0; s = 8'h00;
    run16 = 1'b1; cl16 = 1'b1; sm16 = 1'b0; s16 = 16'h0000;
    #12;
    checks++;
    if ({a8, b8, x8, busy8, done8} !== 19'd0) begin
      errors++;
      $display("FAIL reset: got A=%h B=%h X=%b BUSY=%b DONE=%b want all 0", a8, b8, x8, busy8, done8);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_chain;
    int edges, busyc;
    load_b(8'd11);
    do_run(8'hFD, 1'b1, edges, busyc);
    chk8("chain1", 8'hFF, 8'hDF, 1'b1);
    checks++;
    if (edges !== 17) begin errors++; $display("FAIL latency: got %0d edges want 17", edges); end
    checks++;
    if (busyc !== 16) begin errors++; $display("FAIL busy_len: got %0d cycles want 16", busyc); end
`ifdef MULT_OVF_EN
    checks++;
    if (ovf8 !== 1'b0) begin errors++; $display("FAIL ovf_chain1: got %b want 0", ovf8); end
`endif
    do_run(8'hFD, 1'b1, edges, busyc);
    chk8("chain2", 8'h00, 8'h63, 1'b0);
  endtask

  task automatic test_corner;
    int edges, busyc;
    load_b(8'h80);
    do_run(8'h80, 1'b1, edges, busyc);
    chk8("corner_min", 8'h40, 8'h00, 1'b0);
`ifdef MULT_OVF_EN
    checks++;
    if (ovf8 !== 1'b1) begin errors++; $display("FAIL ovf_corner: got %b want 1", ovf8); end
`endif
    load_b(8'hFF);
    do_run(8'hFF, 1'b1, edges, busyc);
    chk8("corner_m1", 8'h00, 8'h01, 1'b0);
  endtask

  task automatic test_unsigned;
    int edges, busyc;
    load_b(8'hFF);
    do_run(8'hFF, 1'b0, edges, busyc);
    chk8("unsigned_ff", 8'hFE, 8'h01, 1'b0);
`ifdef MULT_OVF_EN
    checks++;
    if (ovf8 !== 1'b1) begin errors++; $display("FAIL ovf_ff: got %b want 1", ovf8); end
`endif
    load_b(8'h0F);
    do_run(8'h0F, 1'b0, edges, busyc);
    chk8("unsigned_0f", 8'h00, 8'hE1, 1'b0);
`ifdef MULT_OVF_EN
    checks++;
    if (ovf8 !== 1'b0) begin errors++; $display("FAIL ovf_0f: got %b want 0", ovf8); end
`endif
  endtask

  task automatic test_priority;
    int busy_seen;
    busy_seen = 0;
    load_b(8'hA5);
    @(negedge clk); cl = 1'b0; run = 1'b0; s = 8'h42; sm = 1'b1;
    @(negedge clk); cl = 1'b1; run = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (busy8 !== 1'b0) busy_seen++;
    end
    chk8("priority_load", 8'h00, 8'h42, 1'b0);
    checks++;
    if (busy_seen !== 0) begin errors++; $display("FAIL priority_busy: got %0d busy cycles want 0", busy_seen); end
  endtask

  task automatic test_hold;
    load_b(8'd3);
    @(negedge clk); run = 1'b0; s = 8'd5; sm = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (done8 !== 1'b1) begin errors++; $display("FAIL hold_done: got %b want 1", done8); end
    chk8("hold_once", 8'h00, 8'd15, 1'b0);
    run = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy8, done8} !== 2'b00) begin errors++; $display("FAIL hold_release: got BUSY=%b DONE=%b want 0 0", busy8, done8); end
  endtask

  task automatic test_async_reset;
    int edges, busyc;
    load_b(8'd5);
    @(negedge clk); run = 1'b0; s = 8'd7; sm = 1'b1;
    repeat (7) @(negedge clk);
    run = 1'b1;
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b want 1", busy8); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a8, b8, x8, busy8, done8} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset: got A=%h B=%h X=%b BUSY=%b DONE=%b want all 0", a8, b8, x8, busy8, done8);
    end
    @(negedge clk); rst_n = 1'b1;
    load_b(8'd6);
    do_run(8'd7, 1'b1, edges, busyc);
    chk8("after_reset", 8'h00, 8'h2A, 1'b0);
  endtask

  task automatic test_width16;
    int lat, busyc;
    lat = 0; busyc = 0;
    @(negedge clk); cl16 = 1'b0; s16 = 16'hFB2E;
    @(negedge clk); cl16 = 1'b1;
    @(negedge clk); run16 = 1'b0; s16 = 16'h0237; sm16 = 1'b1;
    while (done16 !== 1'b1 && lat < 200) begin
      @(negedge clk); lat++;
      if (lat == 1) begin s16 = 16'h1234; sm16 = 1'b0; end
      if (busy16 === 1'b1) busyc++;
    end
    run16 = 1'b1;
    checks++;
    if ({x16, a16, b16} !== {1'b1, 32'hFFF5_52E2}) begin
      errors++;
      $display("FAIL w16_product: got X=%b A:B=%h want X=1 A:B=fff552e2", x16, {a16, b16});
    end
    checks++;
    if (busyc !== 32) begin errors++; $display("FAIL w16_busy: got %0d cycles want 32", busyc); end
    checks++;
    if (lat - 1 !== 33) begin errors++; $display("FAIL w16_latency: got %0d edges want 33", lat - 1); end
  endtask

  initial begin
    test_reset;
    test_chain;
    test_corner;
    test_unsigned;
    test_priority;
    test_hold;
    test_async_reset;
    test_width16;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
